square_seg_display_gen: RTL and testbench
=========================================

// Module: square_seg_display_gen
// PURPOSE
//  Parametrised successor to the fixed 2x2-digit squarer display. A free-running operand counter
//  steps at a divided tick rate. Each step squares the operand with a sequential shift-add unit,
//  converts the result to BCD by sequential double-dabble, and drives NDIGITS seven-segment digits.
//  Top-level board block between the clock/reset pins and the display/LED pins.
// PARAMETERS
//  WIDTH     6   operand width; square is 2*WIDTH bits
//  NDIGITS   4   displayed decimal digits (digit 0 = least significant)
//  TICK_DIV  50  clock cycles per operand tick (>=2)
//  localparam BCD_D = (2*WIDTH*30103)/100000 + 1  internal BCD digit count
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          synchronous reset, active-high
//  en         in   1          count enable; 0 freezes prescaler and counter
//  OPERAND    out  WIDTH      operand currently shown on the display
//  SEG        out  7*NDIGITS  digit i at [7i+6:7i], bit order {g,f,e,d,c,b,a}, active-low
//  LED_RED    out  1          overflow: last result had nonzero digits above NDIGITS
//  LED_GREEN  out  1          toggles on every display update
//  busy       out  1          1 while the FSM is not in IDLE
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, any state):
//   - prescaler=0, counter=0, OPERAND=0, FSM=IDLE, busy=0, LED_RED=0, LED_GREEN=0.
//   - SEG shows 0 on every digit (7'b1000000 each).
//   - An operation in progress is aborted and its result is discarded.
//  Prescaler:
//   - Counts 0..TICK_DIV-1 only while en=1; tick=1 in the cycle it equals TICK_DIV-1, then it wraps to 0.
//  FSM states: IDLE -> MUL -> BCD -> LOAD -> IDLE.
//   - IDLE: on tick, latch opnd=counter, increment counter (wraps 2^WIDTH-1 -> 0), go to MUL.
//     A tick seen in any other state is dropped; the counter does not advance.
//   - MUL: exactly WIDTH cycles of shift-add, product = opnd*opnd, full 2*WIDTH bits, no truncation.
//   - BCD: exactly 2*WIDTH cycles of double-dabble into BCD_D digits (add 3 where digit>=5, then shift).
//   - LOAD: 1 cycle. Registers update in this cycle:
//     - SEG <= decode of the lowest NDIGITS digits.
//     - OPERAND <= opnd.
//     - LED_RED <= |(digits NDIGITS..BCD_D-1); 0 when NDIGITS>=BCD_D.
//     - LED_GREEN toggles.
//  Latency: SEG/OPERAND/LEDs update on the edge 3*WIDTH+2 cycles after the tick-accepting edge.
//   TICK_DIV < 3*WIDTH+3 therefore drops ticks (legal; the counter advances only on accepted ticks).
//  Outputs are registered and hold between updates; en=0 mid-operation does not stall the FSM.
//  Digit decode 0-9 is standard; BCD codes 10-15 cannot occur; decode them to all-off (7'h7F).
// CONFIGURATION
//  SQ_LZ_BLANK_EN defined:
//   - Leading zero digits above digit 0 are blanked (7'h7F).
//   - Digit 0 is always lit; reset shows "0" on digit 0 with the others blank.
//  Not defined: all NDIGITS digits are always lit, zeros included.
// STRUCTURE
//  Package square_seg_pkg: FSM state enum (IDLE, MUL, BCD, LOAD), the 7-seg constant table for 0-9 and BLANK,
//   and function seg7_decode(bcd[3:0]).
//  Sub-module sq_bin2bcd:
//   - Sequential double-dabble; params IN_W, DIGITS.
//   - Ports clk, rst, start, bin, done, bcd.
//   - done pulses after exactly IN_W cycles.
//  Multiplier and prescaler stay inline.
// TESTING
//  1. Defaults, TICK_DIV=50, rst 2 cycles, en=1.
//     -> First update 3*6+2=20 cycles after first tick: OPERAND=0, SEG=0000, LED_GREEN=1.
//     Next update: OPERAND=1, SEG=0001.
//  2. Run to counter=63. -> Display 3969, LED_RED=0; next update OPERAND=0, SEG=0000 (wrap).
//  3. NDIGITS=2, operand 12. -> SEG=44, LED_RED=1; operand 9 -> SEG=81, LED_RED=0.
//  4. Assert rst in the 3rd MUL cycle.
//     -> Next edge: busy=0, SEG all 7'b1000000, LEDs 0; no later update carries the aborted operand.
//  5. en=0 for 200 cycles in IDLE. -> OPERAND, SEG and LED_GREEN stable, busy=0; en=1 resumes from the same count.
//  6. TICK_DIV=5. -> Ticks arriving while busy are dropped; OPERAND still steps 0,1,2,... without gaps.
//   With SQ_LZ_BLANK_EN, operand 3 -> digits {BLANK,BLANK,BLANK,9}.

Source files
------------

// File: rtl/square_seg_pkg.sv
// Shared types and constants for the squarer display.
//   sq_state_e   : control FSM states (IDLE -> MUL -> BCD -> LOAD)
//   SEG_TABLE    : active-low seven-segment patterns for 0-9, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK    : all segments off
//   seg7_decode  : BCD nibble -> segment pattern; codes 10-15 decode to blank
package square_seg_pkg;

  typedef enum logic [1:0] {IDLE, MUL, BCD, LOAD} sq_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // entry k is the pattern for digit k
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
    logic [6:0] s;
    s = SEG_BLANK;
    for (int k = 0; k < 10; k++)
      if (bcd == 4'(k)) s = SEG_TABLE[k];
    return s;
  endfunction

endpackage

// File: rtl/sq_bin2bcd.sv
// Sequential double-dabble binary to BCD converter.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, abandons a conversion in flight
//   start : load bin this cycle; IN_W add-3/shift steps follow, one per cycle
//   bin   : binary input, sampled with start
//   done  : high in the cycle whose closing edge performs the final step,
//           i.e. IN_W cycles after the start cycle; bcd is final after that edge
//   bcd   : DIGITS packed BCD digits, digit 0 in bits [3:0]
module sq_bin2bcd
  import square_seg_pkg::*;
#(
  parameter int IN_W   = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(IN_W + 1);

  logic [IN_W-1:0]     sh_q, sh_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]       cnt_q, cnt_d;   // steps remaining
  logic                act_q, act_d;

  // add 3 to every digit >= 5 before the shift so it carries correctly
  always_comb begin
    adj = bcd_q;
    for (int g = 0; g < DIGITS; g++)
      if (bcd_q[4*g +: 4] >= 4'd5) adj[4*g +: 4] = bcd_q[4*g +: 4] + 4'd3;
  end

  always_comb begin
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    act_d = act_q;
    if (start) begin
      sh_d  = bin;
      bcd_d = '0;
      cnt_d = CW'(IN_W);
      act_d = 1'b1;
    end else if (act_q) begin
      {bcd_d, sh_d} = {adj[4*DIGITS-2:0], sh_q, 1'b0};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) act_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

  assign done = act_q && (cnt_q == CW'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/square_seg_display_gen.sv
// Free-running squarer display. A prescaled tick advances an operand counter;
// each accepted tick squares the operand (shift-add), converts the square to
// BCD (double-dabble) and loads NDIGITS seven-segment digits.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, aborts any operation in flight
//   en        : count enable; freezes prescaler and counter, not the FSM
//   OPERAND   : operand currently displayed
//   SEG       : digit i at [7i+6:7i], {g,f,e,d,c,b,a}, active-low
//   LED_RED   : last result had nonzero digits above the displayed ones
//   LED_GREEN : toggles on every display update
//   busy      : FSM not in IDLE
// Build option SQ_LZ_BLANK_EN: blank leading zero digits (digit 0 always lit).
module square_seg_display_gen
  import square_seg_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int NDIGITS  = 4,
  parameter int TICK_DIV = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [WIDTH-1:0]      OPERAND,
  output logic [7*NDIGITS-1:0]  SEG,
  output logic                  LED_RED,
  output logic                  LED_GREEN,
  output logic                  busy
);

  localparam int BCD_D  = (2*WIDTH*30103)/100000 + 1;
  localparam int PW     = $clog2(TICK_DIV);
  localparam int MW     = $clog2(WIDTH + 1);
  localparam int PROD_W = 2*WIDTH;
  localparam int ND_ALL = (NDIGITS > BCD_D) ? NDIGITS : BCD_D;

  function automatic logic [7*NDIGITS-1:0] seg_rst_fn();
    logic [7*NDIGITS-1:0] s;
    s = '0;
    for (int i = 0; i < NDIGITS; i++) begin
`ifdef SQ_LZ_BLANK_EN
      s[7*i +: 7] = (i == 0) ? SEG_TABLE[0] : SEG_BLANK;
`else
      s[7*i +: 7] = SEG_TABLE[0];
`endif
    end
    return s;
  endfunction

  localparam logic [7*NDIGITS-1:0] SEG_RST = seg_rst_fn();

  sq_state_e            state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 tick;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [PROD_W-1:0]    prod_q, prod_d;
  logic [MW-1:0]        mcnt_q, mcnt_d;
  logic                 go_q, go_d;        // starts the converter one cycle after MUL ends
  logic [WIDTH-1:0]     oper_q, oper_d;
  logic [7*NDIGITS-1:0] seg_q, seg_d, seg_new;
  logic                 red_q, red_d;
  logic                 green_q, green_d;
  logic                 bcd_done;
  logic [4*BCD_D-1:0]   bcd_w;
  logic [4*ND_ALL-1:0]  dig_all;
  logic                 hi_nz;

  // ---- prescaler ----
  assign tick = en && (presc_q == PW'(TICK_DIV-1));

  always_comb begin
    presc_d = presc_q;
    if (en) presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // ---- BCD converter ----
  sq_bin2bcd #(.IN_W(PROD_W), .DIGITS(BCD_D)) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (go_q),
    .bin   (prod_q),
    .done  (bcd_done),
    .bcd   (bcd_w)
  );

  // ---- digit decode ----
  always_comb begin
    dig_all = '0;
    dig_all[4*BCD_D-1:0] = bcd_w;
  end

  // digits beyond the display; zero-width loop when everything fits
  always_comb begin
    hi_nz = 1'b0;
    for (int i = NDIGITS; i < ND_ALL; i++)
      hi_nz = hi_nz | (dig_all[4*i +: 4] != 4'd0);
  end

  always_comb begin
    logic [3:0] d;
`ifdef SQ_LZ_BLANK_EN
    logic       lit;
    // a nonzero hidden digit makes every displayed zero significant
    lit = hi_nz;
`endif
    d       = '0;
    seg_new = '0;
    for (int i = NDIGITS-1; i >= 0; i--) begin
      d = dig_all[4*i +: 4];
`ifdef SQ_LZ_BLANK_EN
      lit = lit | (d != 4'd0) | (i == 0);
      seg_new[7*i +: 7] = lit ? seg7_decode(d) : SEG_BLANK;
`else
      seg_new[7*i +: 7] = seg7_decode(d);
`endif
    end
  end

  // ---- control FSM and datapath next state ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    prod_d  = prod_q;
    mcnt_d  = mcnt_q;
    go_d    = 1'b0;
    oper_d  = oper_q;
    seg_d   = seg_q;
    red_d   = red_q;
    green_d = green_q;
    case (state_q)
      IDLE: begin
        // ticks outside IDLE fall through untouched: dropped
        if (tick) begin
          opnd_d  = cnt_q;
          cnt_d   = cnt_q + WIDTH'(1);
          prod_d  = '0;
          mcnt_d  = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (opnd_q[mcnt_q])
          prod_d = prod_q + ({{WIDTH{1'b0}}, opnd_q} << mcnt_q);
        mcnt_d = mcnt_q + MW'(1);
        if (mcnt_q == MW'(WIDTH-1)) begin
          go_d    = 1'b1;
          state_d = BCD;
        end
      end
      BCD: begin
        if (bcd_done) state_d = LOAD;
      end
      LOAD: begin
        seg_d   = seg_new;
        oper_d  = opnd_q;
        red_d   = hi_nz;
        green_d = ~green_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      opnd_q  <= '0;
      prod_q  <= '0;
      mcnt_q  <= '0;
      go_q    <= 1'b0;
      oper_q  <= '0;
      seg_q   <= SEG_RST;
      red_q   <= 1'b0;
      green_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      prod_q  <= prod_d;
      mcnt_q  <= mcnt_d;
      go_q    <= go_d;
      oper_q  <= oper_d;
      seg_q   <= seg_d;
      red_q   <= red_d;
      green_q <= green_d;
    end
  end

  assign OPERAND   = oper_q;
  assign SEG       = seg_q;
  assign LED_RED   = red_q;
  assign LED_GREEN = green_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_square_seg_display_gen.sv
// Bench for square_seg_display_gen: instance a uses the default geometry,
// instance b uses NDIGITS=2 and TICK_DIV=5 so ticks are dropped while busy.
// A spec-level model predicts each accepted tick and queues the display
// update it must produce; a negedge monitor pops and compares on every
// LED_GREEN toggle and checks outputs hold between updates.
module tb_square_seg_display_gen;

  localparam int W    = 6;
  localparam int ND_A = 4;
  localparam int TD_A = 50;
  localparam int ND_B = 2;
  localparam int TD_B = 5;
  localparam int LAT  = 3*W + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rst_b, en_b;
  logic [W-1:0]      op_a, op_b;
  logic [7*ND_A-1:0] seg_a;
  logic [7*ND_B-1:0] seg_b;
  logic red_a, green_a, busy_a, red_b, green_b, busy_b;

  square_seg_display_gen #(.WIDTH(W), .NDIGITS(ND_A), .TICK_DIV(TD_A)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .OPERAND(op_a), .SEG(seg_a),
    .LED_RED(red_a), .LED_GREEN(green_a), .busy(busy_a)
  );

  square_seg_display_gen #(.WIDTH(W), .NDIGITS(ND_B), .TICK_DIV(TD_B)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .OPERAND(op_b), .SEG(seg_b),
    .LED_RED(red_b), .LED_GREEN(green_b), .busy(busy_b)
  );

  typedef struct packed {
    int          op;
    logic [27:0] seg;
    logic        red;
    int          due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // per-instance model state, index 0 = a, 1 = b
  int   presc[2], cnt[2], free_c[2], last_acc[2], upd[2];
  logic rst_edge[2], armed[2], prev_green[2], hold_red[2];
  int   hold_op[2];
  logic [27:0] hold_seg[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [6:0] lut(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int nd_of(input int k);
    return (k == 0) ? ND_A : ND_B;
  endfunction

  function automatic logic [27:0] exp_seg(input int sq, input int nd);
    logic [27:0] s;
    int p;
    s = '0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      s[7*i +: 7] = lut((sq / p) % 10);
`ifdef SQ_LZ_BLANK_EN
      if (i > 0 && sq < p) s[7*i +: 7] = 7'h7F;
`endif
      p = p * 10;
    end
    return s;
  endfunction

  function automatic logic [27:0] rst_seg(input int nd);
    logic [27:0] s;
    s = '0;
    for (int i = 0; i < nd; i++) begin
      s[7*i +: 7] = 7'h40;
`ifdef SQ_LZ_BLANK_EN
      if (i > 0) s[7*i +: 7] = 7'h7F;
`endif
    end
    return s;
  endfunction

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // predict edge nxt given the inputs that edge will sample
  task automatic model(input int k, input int nxt, input logic r, input logic e);
    exp_t x;
    int td, sq;
    td = (k == 0) ? TD_A : TD_B;
    rst_edge[k] = r;
    if (r) begin
      presc[k] = 0; cnt[k] = 0; free_c[k] = 0; last_acc[k] = -100;
      if (k == 0) q_a.delete(); else q_b.delete();
    end else if (e) begin
      if (presc[k] == td-1) begin
        presc[k] = 0;
        if (nxt >= free_c[k]) begin
          sq    = cnt[k] * cnt[k];
          x.op  = cnt[k];
          x.seg = exp_seg(sq, nd_of(k));
          x.red = (sq >= pow10(nd_of(k)));
          x.due = nxt + LAT;
          if (k == 0) q_a.push_back(x); else q_b.push_back(x);
          last_acc[k] = nxt;
          free_c[k]   = nxt + LAT + 1;
          cnt[k]      = (cnt[k] + 1) % (1 << W);
        end
      end else begin
        presc[k]++;
      end
    end
  endtask

  task automatic check_dut(input int k, input int c, input logic [W-1:0] op,
                           input logic [27:0] seg, input logic red,
                           input logic green, input logic bsy);
    exp_t e;
    int   qs;
    logic exp_busy;
    if (!rst_edge[k] && !armed[k]) return;
    qs = (k == 0) ? q_a.size() : q_b.size();
    if (rst_edge[k]) begin
      armed[k]      = 1'b1;
      prev_green[k] = 1'b0;
      hold_op[k]    = 0;
      hold_seg[k]   = rst_seg(nd_of(k));
      hold_red[k]   = 1'b0;
      chk("rst_busy", bsy, 1'b0);
      chk("rst_green", green, 1'b0);
    end else begin
      exp_busy = (c >= last_acc[k]) && (c <= free_c[k] - 2);
      chk("busy", bsy, exp_busy);
      if (green != prev_green[k]) begin
        if (qs == 0) begin
          chk("spurious_upd", green, prev_green[k]);
        end else begin
          e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
          chk("upd_cycle", c, e.due);
          hold_op[k]  = e.op;
          hold_seg[k] = e.seg;
          hold_red[k] = e.red;
          upd[k]++;
        end
        prev_green[k] = green;
      end else if (qs > 0) begin
        e = (k == 0) ? q_a[0] : q_b[0];
        if (e.due <= c) begin
          chk("missing_upd", green, ~prev_green[k]);
          if (k == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
        end
      end
    end
    chk("operand", op, hold_op[k]);
    chk("seg", seg, hold_seg[k]);
    chk("led_red", red, hold_red[k]);
  endtask

  // monitor: check edge cyc, then predict edge cyc+1
  initial begin
    for (int k = 0; k < 2; k++) begin
      presc[k] = 0; cnt[k] = 0; free_c[k] = 0; last_acc[k] = -100; upd[k] = 0;
      rst_edge[k] = 1'b0; armed[k] = 1'b0; prev_green[k] = 1'b0;
      hold_op[k] = 0; hold_seg[k] = '0; hold_red[k] = 1'b0;
    end
    #1;
    model(0, 1, rst_a, en_a);
    model(1, 1, rst_b, en_b);
    forever begin
      @(negedge clk);
      cyc++;
      check_dut(0, cyc, op_a, {{(28-7*ND_A){1'b0}}, seg_a}, red_a, green_a, busy_a);
      check_dut(1, cyc, op_b, {{(28-7*ND_B){1'b0}}, seg_b}, red_b, green_b, busy_b);
      model(0, cyc+1, rst_a, en_a);
      model(1, cyc+1, rst_b, en_b);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1;

    // full sweep through 63 and the wrap back to 0
    for (int i = 0; i < 5000 && upd[0] < 66; i++) @(posedge clk);
    chk("a_wrap_seen", upd[0] >= 66, 1'b1);

    // pause in IDLE right after an update
    n = upd[0];
    for (int i = 0; i < 200 && upd[0] == n; i++) @(posedge clk);
    #2;
    en_a = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    chk("pause_busy", busy_a, 1'b0);
    chk("pause_op", op_a, hold_op[0]);
    en_a = 1'b1;
    n = upd[0];
    for (int i = 0; i < 300 && upd[0] < n + 2; i++) @(posedge clk);
    chk("resume_upd", upd[0] >= n + 2, 1'b1);

    // reset in the 3rd MUL cycle
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (last_acc[0] == cyc + 1) break;
    end
    chk("abort_sync", last_acc[0], cyc + 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_a = 1'b1;
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    n = upd[0];
    for (int i = 0; i < 400 && upd[0] < n + 3; i++) @(posedge clk);
    chk("post_abort_upd", upd[0] >= n + 3, 1'b1);

    chk("b_updates", upd[1] >= 64, 1'b1);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
